// File: rtl/ssd1306_pkg.sv
// rtl/ssd1306_pkg.sv - shared state encoding and defaults for the SSD1306 SPI transmitter
package ssd1306_pkg;

    localparam int WORD_LEN_DEF   = 8;
    localparam int PRESCALE_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCK_HI,
        SCK_LO,
        HOLD
    } tx_state_t;

    // Bit counter width; a single-bit word still needs a one-bit counter.
    function automatic int bit_cnt_w(input int word_len);
        return (word_len > 1) ? $clog2(word_len) : 1;
    endfunction

endpackage

// File: rtl/ssd1306_spi_tx_if.sv
// rtl/ssd1306_spi_tx_if.sv - upstream byte handshake between a sequencer and the SSD1306 transmitter
interface ssd1306_spi_tx_if
    import ssd1306_pkg::*;
#(
    parameter int WORD_LEN   = WORD_LEN_DEF,
    parameter int PRESCALE_W = PRESCALE_W_DEF
) ();

    logic                  tx_valid;
    logic                  tx_ready;
    logic [WORD_LEN-1:0]   tx_data;
    logic                  tx_dc;
    logic [PRESCALE_W-1:0] prescale;
    logic                  tx_done;
    logic                  busy;

    modport master (
        output tx_valid, tx_data, tx_dc, prescale,
        input  tx_ready, tx_done, busy
    );

    modport slave (
        input  tx_valid, tx_data, tx_dc, prescale,
        output tx_ready, tx_done, busy
    );

endinterface

// File: rtl/ssd1306_half_tick.sv
// rtl/ssd1306_half_tick.sv - SCLK half-period down-counter, reloaded on every state entry
module ssd1306_half_tick
    import ssd1306_pkg::*;
#(
    parameter int PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                  clk_50M,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [PRESCALE_W-1:0] p,
    output logic                  tc
);

    logic [PRESCALE_W-1:0] cnt;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= p;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/ssd1306_spi_tx.sv
// rtl/ssd1306_spi_tx.sv - mode-0 SPI byte transmitter driving an SSD1306 panel (SCLK, SDIN, D/C, CS#)
module ssd1306_spi_tx
    import ssd1306_pkg::*;
#(
    parameter int WORD_LEN   = WORD_LEN_DEF,
    parameter int PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic              clk_50M,
    input  logic              rst_n,
    ssd1306_spi_tx_if.slave   bus,
    output logic              oled_sclk,
    output logic              oled_sdin,
    output logic              oled_dc,
    output logic              oled_cs_n
);

    localparam int CNT_W = bit_cnt_w(WORD_LEN);

    tx_state_t             state;
    logic [WORD_LEN-1:0]   shreg;
    logic [CNT_W-1:0]      bit_cnt;
    logic [PRESCALE_W-1:0] p_q;
    logic                  ready_q;
    logic                  done_q;
    logic                  accept;
    logic                  load;
    logic                  tc;
    logic [PRESCALE_W-1:0] tick_p;

    assign accept = bus.tx_valid & ready_q;

    // On accept the latched P is not yet available, so load straight from the input.
    assign load   = (state == IDLE) ? accept : tc;
    assign tick_p = (state == IDLE) ? bus.prescale : p_q;

    ssd1306_half_tick #(
        .PRESCALE_W (PRESCALE_W)
    ) u_half_tick (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .load    (load),
        .p       (tick_p),
        .tc      (tc)
    );

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            p_q       <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            oled_sclk <= 1'b0;
            oled_dc   <= 1'b0;
            oled_cs_n <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= SETUP;
                        shreg     <= bus.tx_data;
                        p_q       <= bus.prescale;
                        bit_cnt   <= CNT_W'(WORD_LEN - 1);
                        oled_dc   <= bus.tx_dc;
                        oled_cs_n <= 1'b0;
                        ready_q   <= 1'b0;
                    end
                end
                SETUP, SCK_LO: begin
                    if (tc) begin
                        state     <= SCK_HI;
                        oled_sclk <= 1'b1;
                    end
                end
                SCK_HI: begin
                    if (tc) begin
                        oled_sclk <= 1'b0;
                        // Leave on the last bit before the counter can wrap.
                        if (bit_cnt == '0) begin
                            state <= HOLD;
                        end else begin
                            state   <= SCK_LO;
                            bit_cnt <= bit_cnt - 1'b1;
                            shreg   <= shreg << 1;
                        end
                    end
                end
                HOLD: begin
                    if (tc) begin
                        state     <= IDLE;
                        shreg     <= '0;
                        oled_cs_n <= 1'b1;
                        ready_q   <= 1'b1;
                        done_q    <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign oled_sdin    = shreg[WORD_LEN-1];
    assign bus.tx_ready = ready_q;
    assign bus.busy     = ~ready_q;
    assign bus.tx_done  = done_q;

endmodule

// File: tb/tb_ssd1306_spi_tx.sv
// tb/tb_ssd1306_spi_tx.sv - directed self-checking bench for ssd1306_spi_tx
module tb_ssd1306_spi_tx;

    logic clk_50M;
    logic rst_n;
    logic oled_sclk, oled_sdin, oled_dc, oled_cs_n;
    int   n_tests;
    int   n_fail;

    ssd1306_spi_tx_if #(.WORD_LEN(8), .PRESCALE_W(8)) bus ();

    ssd1306_spi_tx #(.WORD_LEN(8), .PRESCALE_W(8)) dut (
        .clk_50M   (clk_50M),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .oled_sclk (oled_sclk),
        .oled_sdin (oled_sdin),
        .oled_dc   (oled_dc),
        .oled_cs_n (oled_cs_n)
    );

    initial clk_50M = 1'b0;
    always #10 clk_50M = ~clk_50M;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic start(input logic [7:0] d, input logic dc, input logic [7:0] p);
        @(negedge clk_50M);
        bus.tx_data  = d;
        bus.tx_dc    = dc;
        bus.prescale = p;
        bus.tx_valid = 1'b1;
        @(posedge clk_50M);
        #1;
        bus.tx_valid = 1'b0;
    endtask

    // Observes one byte from the negedge after the accept edge (k = 0) until tx_done.
    task automatic capture(input logic exp_dc, input bit perturb, input bit pulse_valid,
                           output logic [7:0] bits, output int npulse, output int lat,
                           output int hi_min, output int hi_max, output int lo_min,
                           output int lo_max, output int dc_bad, output int cs_bad);
        logic prev_sclk;
        int   hi_run, lo_run;
        bits = '0; npulse = 0; lat = -1; dc_bad = 0; cs_bad = 0;
        hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
        prev_sclk = 1'b0; hi_run = 0; lo_run = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk_50M);
            if (bus.tx_done === 1'b1) begin
                lat = k;
                break;
            end
            if (oled_dc !== exp_dc) dc_bad++;
            if (oled_cs_n !== 1'b0) cs_bad++;
            if (oled_sclk === 1'b1) begin
                if (!prev_sclk) begin
                    if (npulse > 0) begin
                        if (lo_run < lo_min) lo_min = lo_run;
                        if (lo_run > lo_max) lo_max = lo_run;
                    end
                    bits = {bits[6:0], oled_sdin};
                    npulse++;
                    hi_run = 0;
                end
                hi_run++;
            end else begin
                if (prev_sclk) begin
                    if (hi_run < hi_min) hi_min = hi_run;
                    if (hi_run > hi_max) hi_max = hi_run;
                    lo_run = 0;
                end
                lo_run++;
            end
            prev_sclk = oled_sclk;
            if (perturb && k == 1) begin
                bus.tx_data  = ~bus.tx_data;
                bus.prescale = bus.prescale + 8'd2;
                bus.tx_dc    = ~bus.tx_dc;
            end
            if (pulse_valid && k == 4) begin
                bus.tx_data  = 8'h00;
                bus.tx_valid = 1'b1;
            end
            if (pulse_valid && k == 5) bus.tx_valid = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk_50M);
        n_tests++; if (oled_sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk got %b want 0", oled_sclk); end
        n_tests++; if (oled_sdin !== 1'b0) begin n_fail++; $display("FAIL reset_sdin got %b want 0", oled_sdin); end
        n_tests++; if (oled_dc !== 1'b0) begin n_fail++; $display("FAIL reset_dc got %b want 0", oled_dc); end
        n_tests++; if (oled_cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n got %b want 1", oled_cs_n); end
        n_tests++; if (bus.tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", bus.tx_ready); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_tests++; if (bus.tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.tx_done); end
        rst_n = 1'b1;
    endtask

    task automatic test_p0_a5;
        logic [7:0] bits; int np, lat, hmin, hmax, lmin, lmax, dcb, csb;
        start(8'hA5, 1'b0, 8'd0);
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL p0_busy got %b want 1", bus.busy); end
        capture(1'b0, 0, 0, bits, np, lat, hmin, hmax, lmin, lmax, dcb, csb);
        n_tests++; if (bits !== 8'hA5) begin n_fail++; $display("FAIL p0_bits got %h want a5", bits); end
        n_tests++; if (np !== 8) begin n_fail++; $display("FAIL p0_pulses got %0d want 8", np); end
        n_tests++; if (lat !== 17) begin n_fail++; $display("FAIL p0_latency got %0d want 17", lat); end
        n_tests++; if (hmin !== 1 || hmax !== 1 || lmin !== 1 || lmax !== 1) begin
            n_fail++; $display("FAIL p0_phase got hi %0d..%0d lo %0d..%0d want 1", hmin, hmax, lmin, lmax); end
        n_tests++; if (dcb !== 0 || csb !== 0) begin n_fail++; $display("FAIL p0_dc_cs got dc_bad %0d cs_bad %0d want 0", dcb, csb); end
        n_tests++; if (oled_cs_n !== 1'b1 || bus.tx_ready !== 1'b1) begin
            n_fail++; $display("FAIL p0_done_idle got cs_n %b ready %b want 1 1", oled_cs_n, bus.tx_ready); end
    endtask

    task automatic test_p3_af;
        logic [7:0] bits; int np, lat, hmin, hmax, lmin, lmax, dcb, csb;
        start(8'hAF, 1'b1, 8'd3);
        capture(1'b1, 0, 0, bits, np, lat, hmin, hmax, lmin, lmax, dcb, csb);
        n_tests++; if (bits !== 8'hAF) begin n_fail++; $display("FAIL p3_bits got %h want af", bits); end
        n_tests++; if (lat !== 68) begin n_fail++; $display("FAIL p3_latency got %0d want 68", lat); end
        n_tests++; if (hmin !== 4 || hmax !== 4 || lmin !== 4 || lmax !== 4) begin
            n_fail++; $display("FAIL p3_phase got hi %0d..%0d lo %0d..%0d want 4", hmin, hmax, lmin, lmax); end
        n_tests++; if (dcb !== 0) begin n_fail++; $display("FAIL p3_dc got dc_bad %0d want 0", dcb); end
        n_tests++; if (oled_sdin !== 1'b0) begin n_fail++; $display("FAIL p3_idle_sdin got %b want 0", oled_sdin); end
        @(negedge clk_50M);
        n_tests++; if (bus.tx_done !== 1'b0) begin n_fail++; $display("FAIL p3_done_width got %b want 0", bus.tx_done); end
        repeat (3) @(negedge clk_50M);
        n_tests++; if (oled_dc !== 1'b1) begin n_fail++; $display("FAIL p3_dc_hold got %b want 1", oled_dc); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] bits; int np, lat, hmin, hmax, lmin, lmax, dcb, csb;
        @(negedge clk_50M);
        bus.tx_data = 8'hAE; bus.tx_dc = 1'b0; bus.prescale = 8'd1; bus.tx_valid = 1'b1;
        @(posedge clk_50M);
        #1;
        bus.tx_data = 8'h81;
        capture(1'b0, 0, 0, bits, np, lat, hmin, hmax, lmin, lmax, dcb, csb);
        n_tests++; if (bits !== 8'hAE) begin n_fail++; $display("FAIL b2b_first_bits got %h want ae", bits); end
        n_tests++; if (lat !== 34) begin n_fail++; $display("FAIL b2b_first_latency got %0d want 34", lat); end
        n_tests++; if (oled_cs_n !== 1'b1 || bus.tx_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_gap got cs_n %b ready %b want 1 1", oled_cs_n, bus.tx_ready); end
        @(posedge clk_50M);
        #1;
        bus.tx_valid = 1'b0;
        capture(1'b0, 0, 0, bits, np, lat, hmin, hmax, lmin, lmax, dcb, csb);
        n_tests++; if (csb !== 0) begin n_fail++; $display("FAIL b2b_cs_low got cs_bad %0d want 0", csb); end
        n_tests++; if (bits !== 8'h81) begin n_fail++; $display("FAIL b2b_second_bits got %h want 81", bits); end
        n_tests++; if (lat !== 34) begin n_fail++; $display("FAIL b2b_second_latency got %0d want 34", lat); end
    endtask

    task automatic test_reset_mid_byte;
        logic [7:0] bits; int np, lat, hmin, hmax, lmin, lmax, dcb, csb;
        int rises, dones;
        logic prev;
        rises = 0; dones = 0; prev = 1'b0;
        start(8'hC3, 1'b1, 8'd1);
        for (int k = 0; k < 100 && rises < 3; k++) begin
            @(negedge clk_50M);
            if (oled_sclk === 1'b1 && !prev) rises++;
            prev = oled_sclk;
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++; if (oled_cs_n !== 1'b1 || oled_sclk !== 1'b0) begin
            n_fail++; $display("FAIL rst_async got cs_n %b sclk %b want 1 0", oled_cs_n, oled_sclk); end
        n_tests++; if (bus.tx_ready !== 1'b1 || oled_dc !== 1'b0) begin
            n_fail++; $display("FAIL rst_async_ready got ready %b dc %b want 1 0", bus.tx_ready, oled_dc); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_50M);
            if (bus.tx_done !== 1'b0) dones++;
        end
        rst_n = 1'b1;
        bus.tx_data = 8'h3C; bus.tx_dc = 1'b0; bus.prescale = 8'd0; bus.tx_valid = 1'b1;
        @(posedge clk_50M);
        #1;
        bus.tx_valid = 1'b0;
        n_tests++; if (dones !== 0) begin n_fail++; $display("FAIL rst_no_done got %0d pulses want 0", dones); end
        capture(1'b0, 0, 0, bits, np, lat, hmin, hmax, lmin, lmax, dcb, csb);
        n_tests++; if (bits !== 8'h3C || lat !== 17) begin
            n_fail++; $display("FAIL rst_recover got bits %h latency %0d want 3c 17", bits, lat); end
    endtask

    task automatic test_change_after_accept;
        logic [7:0] bits; int np, lat, hmin, hmax, lmin, lmax, dcb, csb;
        start(8'h3C, 1'b1, 8'd2);
        capture(1'b1, 1, 0, bits, np, lat, hmin, hmax, lmin, lmax, dcb, csb);
        n_tests++; if (bits !== 8'h3C) begin n_fail++; $display("FAIL latch_bits got %h want 3c", bits); end
        n_tests++; if (lat !== 51) begin n_fail++; $display("FAIL latch_latency got %0d want 51", lat); end
        n_tests++; if (hmin !== 3 || hmax !== 3 || dcb !== 0) begin
            n_fail++; $display("FAIL latch_phase got hi %0d..%0d dc_bad %0d want 3 3 0", hmin, hmax, dcb); end
    endtask

    task automatic test_valid_while_busy;
        logic [7:0] bits; int np, lat, hmin, hmax, lmin, lmax, dcb, csb;
        int extra;
        extra = 0;
        start(8'h5A, 1'b0, 8'd0);
        capture(1'b0, 0, 1, bits, np, lat, hmin, hmax, lmin, lmax, dcb, csb);
        n_tests++; if (bits !== 8'h5A || np !== 8 || lat !== 17) begin
            n_fail++; $display("FAIL busy_byte got bits %h pulses %0d latency %0d want 5a 8 17", bits, np, lat); end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_50M);
            if (oled_cs_n !== 1'b1 || oled_sclk !== 1'b0) extra++;
        end
        n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL busy_ignored got %0d active cycles want 0", extra); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n        = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        bus.tx_dc    = 1'b0;
        bus.prescale = '0;
        test_reset();
        test_p0_a5();
        test_p3_af();
        test_back_to_back();
        test_reset_mid_byte();
        test_change_after_accept();
        test_valid_while_busy();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ssd1306_spi_tx.md
SSD1306_SPI_TX -- requirements
Module: ssd1306_spi_tx

Interface
REQ-001 Parameter WORD_LEN, default 8, bits per transfer, MSB first.
REQ-002 Parameter PRESCALE_W, default 8, width of the prescale input and the half-period counter.
REQ-003 clk_50M  input  1  sole clock, 50 MHz; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 tx_valid  input  1  upstream byte-request strobe.
REQ-006 tx_ready  output  1  block idle and able to accept a byte.
REQ-007 tx_data  input  WORD_LEN  byte to send.
REQ-008 tx_dc  input  1  SSD1306 D/C level for this byte: 0 = command, 1 = data.
REQ-009 prescale  input  PRESCALE_W  SCLK half-period in clk_50M cycles, minus one.
REQ-010 oled_sclk  output  1  SPI clock, SPI mode 0 (idles low).
REQ-011 oled_sdin  output  1  MOSI.
REQ-012 oled_dc  output  1  D/C line to the panel.
REQ-013 oled_cs_n  output  1  active-low chip select.
REQ-014 tx_done  output  1  one-cycle pulse when a byte completes.
REQ-015 busy  output  1  equal to the inverse of tx_ready.

Function
REQ-016 The block SHALL implement states IDLE, SETUP, SCK_HI, SCK_LO and HOLD.
REQ-017 Handshake: a byte SHALL be accepted only on an edge where tx_valid and tx_ready are both 1; tx_ready SHALL be 1 only in IDLE.
REQ-018 On accept, the block SHALL latch tx_data, tx_dc and prescale (P) and enter SETUP; on the next cycle oled_cs_n = 0, oled_dc = tx_dc and oled_sdin = data MSB.
REQ-019 Each of SETUP, SCK_HI, SCK_LO and HOLD SHALL last exactly P+1 cycles, timed by a half-period down-counter reloaded with P on every state entry.
REQ-020 oled_sclk SHALL be 1 only in SCK_HI.
REQ-021 Transition SETUP->SCK_HI; SCK_HI->SCK_LO while bits remain; SCK_HI->HOLD after bit WORD_LEN-1; SCK_LO->SCK_HI.
REQ-022 On entry to SCK_LO, oled_sdin SHALL advance to the next lower bit, so it is stable across every rising SCLK edge.
REQ-023 HOLD->IDLE; in the first IDLE cycle oled_cs_n = 1 and tx_done = 1 for exactly one cycle.
REQ-024 Accept-edge-to-tx_done latency SHALL be (2*WORD_LEN+1)*(P+1) cycles; P = 0 SHALL be legal.
REQ-025 oled_dc SHALL hold its last value in IDLE; oled_sdin SHALL be 0 in IDLE.
REQ-026 Changes on tx_data, tx_dc, prescale or tx_valid after accept SHALL have no effect on the byte in flight.
REQ-027 Back-to-back: tx_valid held high SHALL be accepted in the same IDLE cycle that tx_done pulses, giving exactly one cycle of oled_cs_n = 1 between bytes.
REQ-028 The bit counter SHALL be ceil(log2(WORD_LEN)) bits wide; the counter wrapping SHALL NOT cause an extra SCLK pulse.

Reset
REQ-029 While rst_n = 0, outputs SHALL be: state IDLE, oled_sclk 0, oled_sdin 0, oled_dc 0, oled_cs_n 1, tx_ready 1, busy 0, tx_done 0.
REQ-030 A reset asserted mid-byte SHALL abort the byte immediately with no tx_done pulse.
REQ-031 The first accept SHALL be possible on the first clk_50M rising edge after rst_n deasserts.

Structure
REQ-032 The state encoding and the WORD_LEN/PRESCALE_W defaults SHALL live in the shared package ssd1306_pkg.
REQ-033 The half-period counter SHALL be a sub-module, ssd1306_half_tick, with load and P inputs and a terminal-count output.

Verification
REQ-034 P = 0, send 0xA5 with dc = 0 -> 8 SCLK pulses; MOSI sampled on rising edges = 1,0,1,0,0,1,0,1; tx_done 17 cycles after accept; oled_dc = 0 throughout.
REQ-035 P = 3, send 0xAF with dc = 1 -> each SCLK high/low phase is 4 cycles; tx_done at cycle 68; oled_dc = 1.
REQ-036 Back-to-back 0xAE then 0x81 with tx_valid held high -> second accept in the tx_done cycle; oled_cs_n high for exactly 1 cycle between bytes.
REQ-037 Assert rst_n = 0 after the 3rd rising SCLK edge -> oled_cs_n = 1 and oled_sclk = 0 asynchronously; no tx_done; the next byte sends cleanly.
REQ-038 Change tx_data and prescale one cycle after accept -> the transmitted bits and timing match the originally latched values.
REQ-039 tx_valid pulsed while busy -> ignored; exactly one byte is transmitted.
